fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- RESET_PC, 16'h0000, PC value after reset.
- HALT_OPCODE, 4'hF, instr[15:12] value that halts fetch.
- NOP_INSTR, 16'h0000, bubble encoding that decode treats as no-op.

REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- stall, in, 1, hazard unit requests that IF/ID hold.
- redirect, in, 1, taken branch/jump resolved in ID this cycle.
- redirect_pc, in, 16, redirect target.
- imem_req, out, 1, instruction fetch request.
- imem_addr, out, 16, fetch address.
- imem_rdy, in, 1, imem_data valid for imem_addr this cycle.
- imem_data, in, 16, fetched instruction.
- if_nextpc, out, 16, PC+2 of the instruction presented to IF/ID.
- if_instr, out, 16, instruction presented to IF/ID.
- ifid_en, out, 1, IF/ID write enable.
- ifid_flush, out, 1, IF/ID flush.
- pc, out, 16, current fetch PC.
- halted, out, 1, fetch stopped on a halt instruction.

Function
REQ-004 The FSM SHALL have three states: FETCH (request outstanding), HOLD (fetched instruction buffered during stall) and HALT.
REQ-005 Event priority SHALL be: rst, then redirect, then stall, then normal operation.
REQ-006 On redirect, in any state, the block SHALL:
- load pc <= {redirect_pc[15:1],1'b0};
- discard any buffered or arriving instruction;
- drive ifid_flush=1 and ifid_en=1 for that cycle;
- go to FETCH next cycle.
REQ-007 ifid_flush SHALL be 1 only in cycles where redirect=1.
REQ-008 Without redirect, ifid_en SHALL equal !stall.
REQ-009 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_addr SHALL change only on pc update or redirect; an abandoned request needs no cancel.
REQ-010 In FETCH with imem_rdy=1, stall=0 and no redirect, the block SHALL:
- drive if_instr=imem_data and if_nextpc=pc+2;
- update pc <= pc+2;
- stay in FETCH.
Latency is zero cycles from imem_rdy to presentation.
REQ-011 In FETCH with imem_rdy=1 and stall=1, the block SHALL latch imem_data into the hold buffer, leave pc unchanged, and go to HOLD.
REQ-012 In FETCH with imem_rdy=0 and stall=0, the block SHALL present if_instr=NOP_INSTR (bubble) and leave pc unchanged.
REQ-013 In HOLD, imem_req SHALL be 0. When stall=0, the block SHALL present the buffered instruction with if_nextpc=pc+2, update pc <= pc+2, and go to FETCH.
REQ-014 When the instruction presented has instr[15:12]==HALT_OPCODE (from FETCH or HOLD), the block SHALL:
- deliver it normally;
- leave pc at the halt address (no increment);
- enter HALT.
REQ-015 In HALT, the block SHALL drive imem_req=0 and halted=1, present NOP_INSTR whenever ifid_en=1, and leave HALT only on redirect or rst.
REQ-016 PC arithmetic SHALL be modulo 2^16: pc 16'hFFFE advances to 16'h0000.
REQ-017 When if_instr=NOP_INSTR, if_nextpc SHALL be pc+2, so that its value is deterministic.

Reset
REQ-018 When rst=1 at a clock edge, the block SHALL load:
- pc=RESET_PC;
- state=FETCH;
- hold buffer=NOP_INSTR;
- halted=0.
REQ-019 While rst=1, outputs SHALL be imem_req=0, ifid_en=1, ifid_flush=1 and if_instr=NOP_INSTR; rst overrides redirect and stall.
REQ-020 Reset asserted in HOLD or HALT SHALL discard the buffer and halted state.

Structure
REQ-021 Opcode constants (HALT_OPCODE), NOP_INSTR and the FSM state encoding SHALL live in the shared processor package.
REQ-022 The pc and hold-buffer registers SHALL each be an instance of the existing dff_16bit sub-module; next-state and output logic SHALL be local.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset then imem_rdy=1 every cycle with data 16'h1234, 16'h5678 -> imem_addr 0000, 0002, 0004; if_nextpc 0002, 0004; ifid_en=1.
- imem_rdy=0 for 3 cycles at pc=0004 -> 3 cycles of if_instr=NOP_INSTR with ifid_en=1; pc stays 0004.
- stall=1 in the cycle imem_rdy=1 with data 16'hABCD at pc=0006, stall held 2 cycles -> ifid_en=0, imem_req=0; on stall release if_instr=ABCD, if_nextpc=0008, then imem_addr=0008.
- redirect=1 with redirect_pc=16'h0041 while in HOLD -> ifid_flush=1, buffer dropped, next imem_addr=0040.
- Fetch 16'hF000 at pc=0010 -> delivered once, halted=1, imem_req=0, NOPs follow, pc=0010; a later redirect to 0020 resumes fetch.
- pc=FFFE with imem_rdy=1 -> if_nextpc=0000 and next imem_addr=0000; rst asserted mid-stall -> pc=RESET_PC, FETCH.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the fetch stage: opcode and bubble encodings,
// fetch FSM state encoding, and a small opcode decode helper.
package fetch_unit_pkg;

  localparam logic [3:0]  OPC_HALT  = 4'hF;
  localparam logic [15:0] INSTR_NOP = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'd2;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] halt_op);
    return instr[15:12] == halt_op;
  endfunction

endpackage

// File: rtl/dff_16bit.sv
// 16-bit register with synchronous active-high reset to a parameterised value and load enable.
module dff_16bit #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory, buffers one instruction across a
// stall, handles redirects and stops fetching on a halt instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = OPC_HALT,
  parameter logic [15:0] NOP_INSTR   = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] if_nextpc,
  output logic [15:0] if_instr,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic [15:0] pc,
  output logic        halted
);

  fetch_state_e state_q, state_d;

  logic [15:0] pc_q, pc_d, pc_plus2;
  logic        pc_en;
  logic [15:0] hold_q, hold_d;
  logic        hold_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  dff_16bit #(
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  dff_16bit #(
    .RST_VAL (NOP_INSTR)
  ) u_hold_reg (
    .clk (clk),
    .rst (rst),
    .en  (hold_en),
    .d   (hold_d),
    .q   (hold_q)
  );

  // 16-bit add wraps naturally, so FFFE steps to 0000.
  assign pc_plus2 = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_plus2;
    pc_en      = 1'b0;
    hold_d     = imem_data;
    hold_en    = 1'b0;
    imem_req   = 1'b0;
    if_instr   = NOP_INSTR;
    if_nextpc  = pc_plus2;
    ifid_en    = !stall;
    ifid_flush = 1'b0;

    if (rst) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
    end else if (redirect) begin
      // A request left outstanding in FETCH is simply abandoned; the new address follows.
      imem_req   = (state_q == StFetch);
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      pc_d       = {redirect_pc[15:1], 1'b0};
      pc_en      = 1'b1;
      hold_d     = NOP_INSTR;
      hold_en    = 1'b1;
      state_d    = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_rdy) begin
            if (stall) begin
              hold_en = 1'b1;
              state_d = StHold;
            end else begin
              if_instr = imem_data;
              if (is_halt(imem_data, HALT_OPCODE)) begin
                state_d = StHalt;
              end else begin
                pc_en = 1'b1;
              end
            end
          end
        end
        StHold: begin
          if (!stall) begin
            if_instr = hold_q;
            if (is_halt(hold_q, HALT_OPCODE)) begin
              state_d = StHalt;
            end else begin
              pc_en   = 1'b1;
              state_d = StFetch;
            end
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == StHalt);

endmodule
